// File: rtl/i2c_slave_rx_pkg.sv
// i2c_slave_rx_pkg
//   Shared definitions for the I2C write-only target: FSM state encoding,
//   SDA drive levels and the byte length. Also holds the helpers that
//   decide whether a START or STOP aborts a frame.
package i2c_slave_rx_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ACK_A     = 4'd2,
    ST_DATA1     = 4'd3,
    ST_ACK_1     = 4'd4,
    ST_DATA2     = 4'd5,
    ST_ACK_2     = 4'd6,
    ST_WAIT_STOP = 4'd7
  } state_e;

  // sda_oe levels: ACK pulls the open-drain line low, NACK leaves it released.
  localparam logic SDA_ACK  = 1'b1;
  localparam logic SDA_NACK = 1'b0;

  // Number of bits in a byte. The counter runs to this value so that
  // "all 8 bits in" is visible on the following SCL fall.
  localparam logic [3:0] BYTE_BITS = 4'd8;

  // A START aborts a frame once the address has been ACKed and the word
  // has not yet been delivered (rx_valid fires on entry to ACK_2).
  function automatic logic start_aborts(input state_e s);
    return (s == ST_DATA1) || (s == ST_ACK_1) || (s == ST_DATA2);
  endfunction

  // A STOP aborts a frame from the address ACK onward, until ACK_2.
  function automatic logic stop_aborts(input state_e s);
    return (s == ST_ACK_A) || (s == ST_DATA1) || (s == ST_ACK_1) ||
           (s == ST_DATA2);
  endfunction

endpackage

// File: rtl/i2c_slave_rx_sync_edge.sv
// i2c_slave_rx_sync_edge
//   Synchronizes one asynchronous pad line into the clk domain and reports
//   its level plus single-cycle rise/fall strobes.
// Ports
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   d_i      in   raw pad level (asynchronous)
//   level_o  out  synchronized level
//   rise_o   out  one-cycle strobe on 0->1 of level_o
//   fall_o   out  one-cycle strobe on 1->0 of level_o
module i2c_slave_rx_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  // I2C lines idle high; resetting to 1 avoids a phantom edge after reset.
  parameter logic RST_VAL     = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  =  level_o & ~prev_q;
  assign fall_o  = ~level_o &  prev_q;

endmodule

// File: rtl/i2c_slave_rx.sv
// i2c_slave_rx
//   I2C write-only target. Receives START, addr+W, data1, data2, STOP,
//   ACKs each byte when addressed and delivers {data1, data2} as one word
//   with a single-cycle valid strobe. Aborted frames raise frame_err.
// Ports
//   clk        in   system clock (>= 8x SCL)
//   reset_n    in   asynchronous active-low reset
//   scl_in     in   raw SCL from pad
//   sda_in     in   raw SDA from pad
//   sda_oe     out  1 = pull SDA low (ACK), 0 = release
//   rx_data    out  {data1, data2}, held until the next valid
//   rx_valid   out  one-cycle pulse when rx_data updates
//   frame_err  out  one-cycle pulse on an aborted frame
//   busy       out  high whenever the FSM is not idle
module i2c_slave_rx
  import i2c_slave_rx_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h2A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  output logic        frame_err,
  output logic        busy
);

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;

  i2c_slave_rx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
    .clk    (clk),
    .reset_n(reset_n),
    .d_i    (scl_in),
    .level_o(scl_s),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_slave_rx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
    .clk    (clk),
    .reset_n(reset_n),
    .d_i    (sda_in),
    .level_o(sda_s),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  // Bus conditions: SDA may only change while SCL is high to signal them.
  logic start_ev, stop_ev;
  assign start_ev = sda_fall & scl_s;
  assign stop_ev  = sda_rise & scl_s;

  state_e      state_q,     state_d;
  logic [3:0]  cnt_q,       cnt_d;
  logic [7:0]  shift_q,     shift_d;
  logic [7:0]  data1_q,     data1_d;
  logic [15:0] rx_data_q,   rx_data_d;
  logic        rx_valid_q,  rx_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        sda_oe_q,    sda_oe_d;

  logic byte_done;
  logic addr_match;
  assign byte_done  = scl_fall && (cnt_q == BYTE_BITS);
  assign addr_match = (shift_q[7:1] == SLAVE_ADDR) && !shift_q[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      data1_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      sda_oe_q    <= SDA_NACK;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      data1_q     <= data1_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      sda_oe_q    <= sda_oe_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    data1_d     = data1_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    sda_oe_d    = sda_oe_q;

    if (start_ev) begin
      // Repeated START restarts address reception from any state.
      state_d     = ST_ADDR;
      cnt_d       = '0;
      sda_oe_d    = SDA_NACK;
      frame_err_d = start_aborts(state_q);
    end else if (stop_ev) begin
      state_d     = ST_IDLE;
      sda_oe_d    = SDA_NACK;
      frame_err_d = stop_aborts(state_q);
    end else begin
      unique case (state_q)
        ST_IDLE: ;

        ST_ADDR, ST_DATA1, ST_DATA2: begin
          if (scl_rise && (cnt_q != BYTE_BITS)) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
          end else if (byte_done) begin
            // The ACK drive starts on the fall that ends the 8th bit.
            unique case (state_q)
              ST_ADDR: begin
                if (addr_match) begin
                  state_d  = ST_ACK_A;
                  sda_oe_d = SDA_ACK;
                end else begin
                  state_d  = ST_WAIT_STOP;
                  sda_oe_d = SDA_NACK;
                end
              end
              ST_DATA1: begin
                state_d  = ST_ACK_1;
                sda_oe_d = SDA_ACK;
                data1_d  = shift_q;
              end
              default: begin
                state_d    = ST_ACK_2;
                sda_oe_d   = SDA_ACK;
                rx_data_d  = {data1_q, shift_q};
                rx_valid_d = 1'b1;
              end
            endcase
          end
        end

        // ACK is held through the 9th SCL high and released on its fall.
        ST_ACK_A, ST_ACK_1, ST_ACK_2: begin
          if (scl_fall) begin
            sda_oe_d = SDA_NACK;
            cnt_d    = '0;
            unique case (state_q)
              ST_ACK_A: state_d = ST_DATA1;
              ST_ACK_1: state_d = ST_DATA2;
              default:  state_d = ST_WAIT_STOP;
            endcase
          end
        end

        // Trailing bytes or a foreign frame: stay off the bus until STOP.
        ST_WAIT_STOP: sda_oe_d = SDA_NACK;

        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = SDA_NACK;
        end
      endcase
    end
  end

  assign sda_oe    = sda_oe_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2c_slave_rx.sv
`timescale 1ns/1ps
module tb_i2c_slave_rx;

  localparam int QTR = 500;  // quarter SCL period in ns (25 clk cycles)

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;   // master drive: 1 = released
  logic        sda_line;
  logic        sda_oe;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic        busy;

  // open-drain bus with pull-up
  assign sda_line = m_sda & ~sda_oe;

  always #10 clk = ~clk;

  i2c_slave_rx #(.SLAVE_ADDR(7'h2A), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .scl_in   (m_scl),
    .sda_in   (sda_line),
    .sda_oe   (sda_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- bus-level model ----------------
  int          n_bytes = 0;     // bytes completed since last START
  bit          addressed = 0;
  bit          exp_ack = 0;
  logic [7:0]  d1 = 8'h00;
  logic [15:0] exp_words[$];
  int          err_pending = 0;
  logic [15:0] last_word = 16'h0000;
  int          n_valid = 0;
  int          n_err = 0;
  bit          cmp_en = 0;
  bit          prev_valid = 0;

  task automatic model_byte(input logic [7:0] b);
    if (n_bytes == 0) begin
      addressed = (b[7:1] == 7'h2A) && (b[0] == 1'b0);
      exp_ack   = addressed;
    end else if (n_bytes == 1) begin
      d1      = b;
      exp_ack = addressed;
    end else if (n_bytes == 2) begin
      exp_ack = addressed;
      if (addressed) exp_words.push_back({d1, b});
    end else begin
      exp_ack = 0;
    end
    n_bytes++;
  endtask

  // START or STOP: a frame addressed to us but without both data bytes is aborted
  task automatic model_boundary();
    if (addressed && (n_bytes == 1 || n_bytes == 2)) err_pending++;
    addressed = 0;
    n_bytes   = 0;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("valid_err_excl", {31'd0, rx_valid & frame_err}, 32'd0);
      if (rx_valid) begin
        n_valid++;
        check("rx_valid_width", {31'd0, prev_valid}, 32'd0);
        check("rx_valid_expected", {31'd0, exp_words.size() > 0}, 32'd1);
        if (exp_words.size() > 0) begin
          last_word = exp_words.pop_front();
          check("rx_data_on_valid", {16'd0, rx_data}, {16'd0, last_word});
        end
      end else begin
        check("rx_data_hold", {16'd0, rx_data}, {16'd0, last_word});
      end
      if (frame_err) begin
        n_err++;
        check("frame_err_expected", {31'd0, err_pending > 0}, 32'd1);
        if (err_pending > 0) err_pending--;
      end
      prev_valid = rx_valid;
    end
  end

  // ---------------- master tasks ----------------
  task automatic m_start();
    model_boundary();
    m_sda = 1'b0;
    #(QTR);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    m_scl = 1'b0;
    #(QTR);
  endtask

  task automatic m_rep_start();
    m_sda = 1'b1;
    #(QTR);
    m_scl = 1'b1;
    #(QTR);
    m_start();
  endtask

  task automatic m_stop();
    m_sda = 1'b0;
    #(QTR);
    m_scl = 1'b1;
    #(QTR);
    model_boundary();
    m_sda = 1'b1;
    #(QTR);
    check("busy_after_stop", {31'd0, busy}, 32'd0);
    #(QTR);
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i];
      #(QTR);
      m_scl = 1'b1;
      if (i == 0) model_byte(b);
      #(2*QTR);
      m_scl = 1'b0;
      #(QTR);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b);
    m_sda = 1'b1;
    #(QTR);
    m_scl = 1'b1;
    #(QTR);
    ack = sda_line;
    check("ack_level", {31'd0, ack}, exp_ack ? 32'd0 : 32'd1);
    check("busy_in_frame", {31'd0, busy}, 32'd1);
    #(QTR);
    m_scl = 1'b0;
    #(QTR);
  endtask

  // watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded %0d ns", 2_000_000);
    $fatal(1, "timeout");
  end

  initial begin
    logic a0, a1, a2;
    int   v0, e0;

    #2;
    reset_n = 1'b0;
    cmp_en  = 1;
    #105;
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_rx_data", {16'd0, rx_data}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    #(QTR);

    // 1: good frame A5 3C
    v0 = n_valid; e0 = n_err;
    m_start();
    send_byte(8'h54, a0);
    send_byte(8'hA5, a1);
    send_byte(8'h3C, a2);
    m_stop();
    check("t1_acks", {29'd0, a0, a1, a2}, 32'd0);
    check("t1_rx_data", {16'd0, rx_data}, 32'h0000A53C);
    check("t1_valid_cnt", n_valid - v0, 32'd1);
    check("t1_err_cnt", n_err - e0, 32'd0);

    // 2: wrong address -> NACK, busy until STOP
    v0 = n_valid; e0 = n_err;
    m_start();
    send_byte(8'h56, a0);
    check("t2_nack", {31'd0, a0}, 32'd1);
    check("t2_busy", {31'd0, busy}, 32'd1);
    m_stop();
    check("t2_valid_cnt", n_valid - v0, 32'd0);
    check("t2_err_cnt", n_err - e0, 32'd0);

    // 3: read request -> NACK, stays busy (waiting for STOP)
    v0 = n_valid; e0 = n_err;
    m_start();
    send_byte(8'h55, a0);
    check("t3_nack", {31'd0, a0}, 32'd1);
    send_byte(8'h99, a1);
    check("t3_extra_nack", {31'd0, a1}, 32'd1);
    check("t3_busy", {31'd0, busy}, 32'd1);
    m_stop();
    check("t3_valid_cnt", n_valid - v0, 32'd0);
    check("t3_err_cnt", n_err - e0, 32'd0);

    // 4: partial frame ended by STOP
    v0 = n_valid; e0 = n_err;
    m_start();
    send_byte(8'h54, a0);
    send_byte(8'h11, a1);
    m_stop();
    check("t4_acks", {30'd0, a0, a1}, 32'd0);
    check("t4_err_cnt", n_err - e0, 32'd1);
    check("t4_valid_cnt", n_valid - v0, 32'd0);
    check("t4_rx_data", {16'd0, rx_data}, 32'h0000A53C);

    // 5: partial frame, repeated START, full frame
    v0 = n_valid; e0 = n_err;
    m_start();
    send_byte(8'h54, a0);
    send_byte(8'h11, a1);
    m_rep_start();
    send_byte(8'h54, a0);
    send_byte(8'hBE, a1);
    send_byte(8'hEF, a2);
    m_stop();
    check("t5_acks", {29'd0, a0, a1, a2}, 32'd0);
    check("t5_err_cnt", n_err - e0, 32'd1);
    check("t5_valid_cnt", n_valid - v0, 32'd1);
    check("t5_rx_data", {16'd0, rx_data}, 32'h0000BEEF);

    // 6: reset during the data1 ACK, then a clean frame
    m_start();
    send_byte(8'h54, a0);
    send_bits(8'h77);
    m_sda = 1'b1;
    #(QTR);
    m_scl = 1'b1;
    #(QTR);
    check("t6_ack1_driven", {31'd0, sda_oe}, 32'd1);
    reset_n   = 1'b0;
    n_bytes   = 0;
    addressed = 0;
    last_word = 16'h0000;
    #1;
    check("t6_rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_rx_data", {16'd0, rx_data}, 32'd0);
    #(QTR);
    reset_n = 1'b1;
    #(QTR);
    v0 = n_valid;
    m_start();
    send_byte(8'h54, a0);
    send_byte(8'h01, a1);
    send_byte(8'h02, a2);
    m_stop();
    check("t6_acks", {29'd0, a0, a1, a2}, 32'd0);
    check("t6_valid_cnt", n_valid - v0, 32'd1);
    check("t6_rx_data", {16'd0, rx_data}, 32'h00000102);

    #(QTR);
    check("end_words_drained", exp_words.size(), 32'd0);
    check("end_err_drained", err_pending, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
